// File: rtl/csr_trap_sequencer.sv
// Machine-mode trap/MRET sequencer and arbiter for the single-port machine CSR file.
// Trap entry, MRET and core CSR accesses each own the CSR port for a fixed cycle sequence.
module csr_trap_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [11:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_ack,
    output logic [31:0] core_rdata,
    output logic        trap_done,
    output logic        mret_done,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [31:0] csr_address,
    output logic        csr_en_write,
    output logic        csr_en_read,
    output logic [31:0] csr_data,
    input  logic [31:0] csr_data_out
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [3:0] {
        IDLE,
        T_MEPC, T_MCAUSE, T_RD_ST, T_WR_ST, T_RD_TV, T_REDIR,
        R_RD_ST, R_WR_ST, R_RD_EPC, R_REDIR,
        C_ACC, C_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic        core_we_q, core_we_d;
    logic [11:0] core_addr_q, core_addr_d;
    logic [31:0] core_wdata_q, core_wdata_d;

    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Vectored only for interrupts in mode 01; modes 10/11 fall back to direct.
    function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if (tvec[1:0] == 2'b01 && cause[31])
            return base + {cause[29:0], 2'b00};
        return base;
    endfunction

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        pc_d         = pc_q;
        core_we_d    = core_we_q;
        core_addr_d  = core_addr_q;
        core_wdata_d = core_wdata_q;
        case (state_q)
            IDLE: begin
                if (trap_req) begin
                    state_d = T_MEPC;
                    cause_d = trap_cause;
                    pc_d    = trap_pc;
                end else if (mret_req) begin
                    state_d = R_RD_ST;
                end else if (core_req) begin
                    state_d      = C_ACC;
                    core_we_d    = core_we;
                    core_addr_d  = core_addr;
                    core_wdata_d = core_wdata;
                end
            end
            T_MEPC:   state_d = T_MCAUSE;
            T_MCAUSE: state_d = T_RD_ST;
            T_RD_ST:  state_d = T_WR_ST;
            T_WR_ST:  state_d = T_RD_TV;
            T_RD_TV:  state_d = T_REDIR;
            R_RD_ST:  state_d = R_WR_ST;
            R_WR_ST:  state_d = R_RD_EPC;
            R_RD_EPC: state_d = R_REDIR;
            C_ACC:    state_d = C_ACK;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cause_q      <= '0;
            pc_q         <= '0;
            core_we_q    <= 1'b0;
            core_addr_q  <= '0;
            core_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            pc_q         <= pc_d;
            core_we_q    <= core_we_d;
            core_addr_q  <= core_addr_d;
            core_wdata_q <= core_wdata_d;
        end
    end

    // Read data arrives registered, so write-back and redirect states consume csr_data_out directly.
    logic [11:0] addr12;
    always_comb begin
        addr12         = '0;
        csr_en_write   = 1'b0;
        csr_en_read    = 1'b0;
        csr_data       = '0;
        core_ack       = 1'b0;
        core_rdata     = '0;
        trap_done      = 1'b0;
        mret_done      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            T_MEPC:   begin addr12 = ADDR_MEPC;    csr_en_write = 1'b1; csr_data = pc_q; end
            T_MCAUSE: begin addr12 = ADDR_MCAUSE;  csr_en_write = 1'b1; csr_data = cause_q; end
            T_RD_ST:  begin addr12 = ADDR_MSTATUS; csr_en_read  = 1'b1; end
            T_WR_ST:  begin addr12 = ADDR_MSTATUS; csr_en_write = 1'b1; csr_data = trap_mstatus(csr_data_out); end
            T_RD_TV:  begin addr12 = ADDR_MTVEC;   csr_en_read  = 1'b1; end
            T_REDIR: begin
                redirect_valid = 1'b1;
                trap_done      = 1'b1;
                redirect_pc    = trap_target(csr_data_out, cause_q);
            end
            R_RD_ST:  begin addr12 = ADDR_MSTATUS; csr_en_read  = 1'b1; end
            R_WR_ST:  begin addr12 = ADDR_MSTATUS; csr_en_write = 1'b1; csr_data = mret_mstatus(csr_data_out); end
            R_RD_EPC: begin addr12 = ADDR_MEPC;    csr_en_read  = 1'b1; end
            R_REDIR: begin
                redirect_valid = 1'b1;
                mret_done      = 1'b1;
                redirect_pc    = {csr_data_out[31:1], 1'b0};
            end
            C_ACC: begin
                addr12       = core_addr_q;
                csr_en_write = core_we_q;
                csr_en_read  = ~core_we_q;
                csr_data     = core_we_q ? core_wdata_q : 32'h0;
            end
            C_ACK: begin
                core_ack   = 1'b1;
                core_rdata = core_we_q ? 32'h0 : csr_data_out;
            end
            default: ;
        endcase
    end

    assign csr_address = {20'h0, addr12};
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Scoreboard bench for csr_trap_sequencer with a behavioural single-port CSR file
// (registered read data) standing in for the real register file.
module tb_csr_trap_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        trap_req = 1'b0, mret_req = 1'b0, core_req = 1'b0, core_we = 1'b0;
    logic [31:0] trap_cause = '0, trap_pc = '0, core_wdata = '0;
    logic [11:0] core_addr = '0;
    logic        core_ack, trap_done, mret_done, redirect_valid, busy, csr_en_write, csr_en_read;
    logic [31:0] core_rdata, redirect_pc, csr_address, csr_data;
    logic [31:0] csr_data_out = '0;

    always #5 clock = ~clock;

    csr_trap_sequencer dut (
        .clock(clock), .reset(reset),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_req(mret_req),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata),
        .trap_done(trap_done), .mret_done(mret_done),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .csr_address(csr_address),
        .csr_en_write(csr_en_write), .csr_en_read(csr_en_read),
        .csr_data(csr_data), .csr_data_out(csr_data_out)
    );

    logic [31:0] csr_mem [0:4095];
    always @(posedge clock) begin
        if (csr_en_write) csr_mem[csr_address[11:0]] <= csr_data;
        if (csr_en_read)  csr_data_out <= csr_mem[csr_address[11:0]];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 core ack, 1 trap redirect, 2 mret redirect
        logic [31:0] val;
        int          cyc;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    int   mkind;
    exp_t me;
    always @(negedge clock) begin
        if (!reset) begin
            if (csr_en_write || csr_en_read) begin
                chk("en_excl", 32'(csr_en_write & csr_en_read), 32'h0);
                addr_q.push_back(csr_address);
            end
            if (busy && !csr_en_write) chk("wdata_zero", csr_data, 32'h0);
            if (core_ack || redirect_valid) begin
                mkind = core_ack ? 0 : trap_done ? 1 : mret_done ? 2 : 3;
                chk("redir_pulse", 32'(redirect_valid), 32'(trap_done | mret_done));
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(mkind), 32'hFFFF_FFFF);
                end else begin
                    me = exp_q.pop_front();
                    chk("event_kind", 32'(mkind), 32'(me.kind));
                    chk("event_value", core_ack ? core_rdata : redirect_pc, me.val);
                    chk("event_cycle", 32'(cyc), 32'(me.cyc));
                end
                if (trap_done) trap_req = 1'b0;
                if (mret_done) mret_req = 1'b0;
                if (core_ack)  core_req = 1'b0;
            end
        end
    end

    task automatic core_issue(input logic we, input logic [11:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input int lat);
        core_req = 1'b1; core_we = we; core_addr = a; core_wdata = wd;
        exp_q.push_back('{0, we ? 32'h0 : exp_rd, cyc + lat});
    endtask

    task automatic trap_issue(input logic [31:0] cause, input logic [31:0] pc,
                              input logic [31:0] exp_pc, input int lat);
        trap_req = 1'b1; trap_cause = cause; trap_pc = pc;
        exp_q.push_back('{1, exp_pc, cyc + lat});
    endtask

    task automatic mret_issue(input logic [31:0] exp_pc, input int lat);
        mret_req = 1'b1;
        exp_q.push_back('{2, exp_pc, cyc + lat});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'h0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            trap_req = 1'b0; mret_req = 1'b0; core_req = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cw(input logic [11:0] a, input logic [31:0] d);
        core_issue(1'b1, a, d, 32'h0, 2);
        drain();
    endtask

    task automatic cr(input logic [11:0] a, input logic [31:0] exp);
        core_issue(1'b0, a, 32'h0, exp, 2);
        drain();
    endtask

    logic [31:0] exp_addr [9];

    initial begin
        exp_addr = '{32'h341, 32'h342, 32'h300, 32'h300, 32'h305,
                     32'h300, 32'h300, 32'h341, 32'h304};

        #1;
        chk("rst_outputs", 32'(|{core_ack, core_rdata, trap_done, mret_done, redirect_valid,
                                 redirect_pc, busy, csr_address, csr_en_write, csr_en_read, csr_data}), 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_busy", 32'(busy), 32'h0);

        // Core write then read-back through the sequencer
        cw(12'h301, 32'h4000_1100);
        cr(12'h301, 32'h4000_1100);

        // Direct trap: mode 01 but synchronous cause
        cw(12'h305, 32'h8000_0101);
        cw(12'h300, 32'h0000_0008);
        trap_issue(32'h0000_0002, 32'h0000_1234, 32'h8000_0100, 6);
        drain();
        cr(12'h341, 32'h0000_1234);
        cr(12'h342, 32'h0000_0002);
        cr(12'h300, 32'h0000_1880);

        // Vectored interrupt, mode 11 treated as direct, and target wrap-around
        cw(12'h305, 32'h8000_0001);
        trap_issue(32'h8000_0007, 32'h0000_0040, 32'h8000_001C, 6);
        drain();
        cw(12'h305, 32'h8000_0003);
        trap_issue(32'h8000_0007, 32'h0000_0044, 32'h8000_0000, 6);
        drain();
        cw(12'h305, 32'hFFFF_FFFD);
        trap_issue(32'h8000_0003, 32'h0000_0048, 32'h0000_0008, 6);
        drain();

        // MRET restores mstatus and clears mepc bit 0
        cw(12'h300, 32'h0000_1880);
        cw(12'h341, 32'h0000_1235);
        mret_issue(32'h0000_1234, 4);
        drain();
        cr(12'h300, 32'h0000_1888);

        // All three requesters at once
        cw(12'h305, 32'h0000_0400);
        cw(12'h300, 32'h0000_0008);
        cw(12'h304, 32'h0000_0888);
        addr_q.delete();
        trap_issue(32'h0000_000B, 32'h0000_2000, 32'h0000_0400, 6);
        mret_issue(32'h0000_2000, 11);
        core_issue(1'b0, 12'h304, 32'h0, 32'h0000_0888, 14);
        drain();
        chk("arb_addr_count", 32'(addr_q.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            if (i < addr_q.size()) chk("arb_addr_seq", addr_q[i], exp_addr[i]);
        cr(12'h300, 32'h0000_1888);

        // Reset during T_WR_ST aborts the trap
        cw(12'h305, 32'h8000_0101);
        cw(12'h300, 32'h0000_0008);
        cw(12'h342, 32'h0000_0000);
        trap_req = 1'b1; trap_cause = 32'h0000_0005; trap_pc = 32'h0000_3000;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        trap_req = 1'b0;
        #1;
        chk("midrst_outputs", 32'(|{core_ack, core_rdata, trap_done, mret_done, redirect_valid,
                                    redirect_pc, busy, csr_address, csr_en_write, csr_en_read, csr_data}), 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        cr(12'h342, 32'h0000_0005);
        cr(12'h300, 32'h0000_0008);
        trap_issue(32'h0000_0003, 32'h0000_3004, 32'h8000_0100, 6);
        drain();
        cr(12'h341, 32'h0000_3004);
        cr(12'h300, 32'h0000_1880);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Machine-mode trap/return sequencer and access arbiter for the single-port machine CSR file.
- Owns the CSR file's only port and shares it between three requesters: core CSR instructions, trap entry and MRET.
- On trap entry it writes mepc and mcause, updates mstatus and reads mtvec, then redirects the PC.
- On MRET it restores mstatus and redirects to mepc.

Parameters:
- none (register map fixed: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- trap_req  in  1  trap request, level; held until trap_done
- trap_cause  in  32  mcause value; bit31 = interrupt
- trap_pc  in  32  faulting or interrupted PC for mepc
- mret_req  in  1  MRET request, level; held until mret_done
- core_req  in  1  core CSR access request, level; held until core_ack
- core_we  in  1  1 = write, 0 = read
- core_addr  in  12  CSR address
- core_wdata  in  32  write data
- core_ack  out  1  one-cycle access-complete pulse
- core_rdata  out  32  read data, valid while core_ack = 1
- trap_done  out  1  one-cycle pulse, coincident with redirect
- mret_done  out  1  one-cycle pulse, coincident with redirect
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target
- busy  out  1  state != IDLE
- csr_address  out  32  to CSR file; 12-bit address zero-extended
- csr_en_write  out  1  to CSR file
- csr_en_read  out  1  to CSR file
- csr_data  out  32  CSR write data; 0 when csr_en_write = 0
- csr_data_out  in  32  from CSR file; registered, valid the cycle after csr_en_read

Behaviour:
- Reset is asynchronous.
  - State returns to IDLE and latched cause, PC and core fields clear to 0.
  - All outputs are 0.
  - Reset mid-sequence aborts the sequence with no done, ack or redirect pulse; partial CSR writes already made stand.
- All outputs are decoded from the current state and latched registers.
- Exactly one of csr_en_write or csr_en_read is high in any cycle, or neither.
- IDLE arbitration samples requests with fixed priority: trap_req > mret_req > core_req.
  - The winner's inputs are latched on acceptance.
  - Losing requests stay pending; no starvation guarantee for core.
- Trap sequence (acceptance cycle = IDLE cycle 0):
  - T_MEPC (cycle 1): write mepc = trap_pc.
  - T_MCAUSE (cycle 2): write mcause = trap_cause.
  - T_RD_ST (cycle 3): read mstatus.
  - T_WR_ST (cycle 4): write mstatus = csr_data_out with MPIE(7) = old MIE(3), MIE = 0, MPP[12:11] = 2'b11.
  - T_RD_TV (cycle 5): read mtvec.
  - T_REDIR (cycle 6): redirect_valid = trap_done = 1.
    - If mtvec[1:0] = 01 and cause[31] = 1: redirect_pc = {mtvec[31:2],2'b00} + (cause[30:0] << 2), modulo 2^32.
    - Otherwise: redirect_pc = {mtvec[31:2],2'b00}; modes 10 and 11 are treated as direct.
  - Then IDLE.
- MRET sequence:
  - R_RD_ST (cycle 1): read mstatus.
  - R_WR_ST (cycle 2): write mstatus with MIE = old MPIE, MPIE = 1, MPP = 2'b11.
  - R_RD_EPC (cycle 3): read mepc.
  - R_REDIR (cycle 4): redirect_valid = mret_done = 1, redirect_pc = {csr_data_out[31:1],1'b0}.
  - Then IDLE.
- Core access:
  - C_ACC (cycle 1): csr_address = core_addr; drive csr_en_write with core_wdata, or csr_en_read.
  - C_ACK (cycle 2): core_ack = 1. For reads, core_rdata = csr_data_out; for writes, core_rdata = 0.
  - Then IDLE.
- Back-to-back operation: IDLE is always visited between operations, so a new acceptance occurs at the earliest in the cycle after the done/ack pulse.
- Requests arriving while busy are ignored until IDLE.
- Unmapped core addresses are passed through: reads return the CSR file's 0, writes are dropped by the CSR file.

Test Plan:
- Reset, then idle: all outputs 0; core read 0x301 (after writing 0x40001100) → core_ack 2 cycles after acceptance, core_rdata = 0x40001100.
- Direct trap: mtvec = 0x80000101 (direct, bits[1:0] = 01 but cause[31] = 0), mstatus = 0x00000008, trap_cause = 0x00000002, trap_pc = 0x00001234 → mepc = 0x1234, mcause = 2, mstatus = 0x00001880; redirect_pc = 0x80000100 in cycle 6.
- Vectored interrupt: mtvec = 0x80000001, trap_cause = 0x80000007 → redirect_pc = 0x8000001C; mtvec = 0x80000003 with same cause → 0x80000000.
- MRET: mstatus = 0x00001880, mepc = 0x00001235 → mstatus = 0x00001888, redirect_pc = 0x00001234 in cycle 4, mret_done pulse.
- Arbitration: trap_req, mret_req and core_req asserted together → trap completes first, then MRET, then core access; verify no overlapping CSR enables and the per-cycle address sequence 341, 342, 300, 300, 305, …
- Reset asserted in T_WR_ST → outputs 0 immediately, no redirect; after release a new trap runs the full 6-cycle sequence.
